// File: rtl/ee552_pkg.sv
// Shared NoC definitions and sizing for the spiking-conv accelerator.
// Packet layout is {dest, opcode, data}; the row RAM holds NUM_TS timesteps of ifmap rows.
package ee552_pkg;

  localparam int unsigned IFMAP_SIZE  = 25;
  localparam int unsigned FILTER_SIZE = 5;
  localparam int unsigned OUTPUT_DIM  = IFMAP_SIZE - FILTER_SIZE + 1;
  localparam int unsigned NUM_PE      = 5;
  localparam int unsigned PPE_BASE_ID = 5;
  localparam int unsigned IMEM_ID     = 11;
  localparam int unsigned NUM_TS      = 2;

  localparam int unsigned DEST_W = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = IFMAP_SIZE;
  localparam int unsigned PKT_W  = DEST_W + OP_W + DATA_W;

  localparam int unsigned ROW_W     = $clog2(IFMAP_SIZE);
  localparam int unsigned TS_W      = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
  localparam int unsigned RAM_DEPTH = NUM_TS * IFMAP_SIZE;
  localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH);
  localparam int unsigned PE_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned CNT_W     = $clog2(OUTPUT_DIM + 1);

  localparam logic [OP_W-1:0] OP_WEIGHT        = 4'd0;
  localparam logic [OP_W-1:0] OP_INPUT         = 4'd1;
  localparam logic [OP_W-1:0] OP_TIMESTEP_DONE = 4'd15;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] data;
  } noc_pkt_t;

  // Flat RAM address of a row within a timestep.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [TS_W-1:0] ts,
                                                 input logic [ROW_W-1:0] row);
    return ADDR_W'(ts) * ADDR_W'(IFMAP_SIZE) + ADDR_W'(row);
  endfunction

endpackage

// File: rtl/imem_row_ram.sv
// Ifmap row storage: one write port, one synchronous read port, no reset on contents.
module imem_row_ram
  import ee552_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  // Writes past the populated depth are discarded rather than aliased.
  always_ff @(posedge clk) begin
    if (we && (waddr < ADDR_W'(RAM_DEPTH))) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_input_server.sv
// Input-memory node: kicks the first row to every partial PE, then answers each
// PE request with its next row or a timestep-done marker, for every stored timestep.
module imem_input_server
  import ee552_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [TS_W-1:0]   load_ts,
  input  logic [ROW_W-1:0]  load_row,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PKT_W-1:0]  in_packet,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  out_packet,
  output logic              busy,
  output logic              done,
  output logic              err_bad_req
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_KICK     = 3'd1;
  localparam logic [2:0] S_WAIT_REQ = 3'd2;
  localparam logic [2:0] S_LOOKUP   = 3'd3;
  localparam logic [2:0] S_SEND     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0] state, state_d;
  logic [TS_W-1:0] ts, ts_d;
  logic [NUM_PE-1:0][CNT_W-1:0] cnt, cnt_d;
  logic [NUM_PE-1:0] fin, fin_d;
  logic [PE_W-1:0] kidx, kidx_d;
  logic kicking, kicking_d;
  logic [PE_W-1:0] resp_k, resp_k_d;
  logic resp_done, resp_done_d;
  noc_pkt_t out_pkt, out_pkt_d;
  logic out_valid_d, in_ready_d, busy_d, done_d, err_d;

  logic [ADDR_W-1:0] ram_raddr_c;
  logic [DATA_W-1:0] ram_rdata;

  noc_pkt_t req_pkt;
  logic req_in_range, req_ok;
  logic [PE_W-1:0] req_idx;
  logic unused_req_data;

  assign req_pkt         = noc_pkt_t'(in_packet);
  assign unused_req_data = ^req_pkt.data;
  assign req_in_range    = (req_pkt.opcode >= OP_W'(PPE_BASE_ID)) &&
                           (req_pkt.opcode < OP_W'(PPE_BASE_ID + NUM_PE));
  assign req_idx         = req_in_range ? PE_W'(req_pkt.opcode - OP_W'(PPE_BASE_ID)) : '0;
  assign req_ok          = (req_pkt.dest == DEST_W'(IMEM_ID)) && req_in_range && !fin[req_idx];
  assign out_packet      = out_pkt;

  imem_row_ram u_ram (
    .clk   (clk),
    .we    (load_en && !busy),
    .waddr (row_addr(load_ts, load_row)),
    .wdata (load_data),
    .raddr (ram_raddr_c),
    .rdata (ram_rdata)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ts          <= '0;
      cnt         <= '0;
      fin         <= '0;
      kidx        <= '0;
      kicking     <= 1'b0;
      resp_k      <= '0;
      resp_done   <= 1'b0;
      out_pkt     <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_bad_req <= 1'b0;
    end else begin
      state       <= state_d;
      ts          <= ts_d;
      cnt         <= cnt_d;
      fin         <= fin_d;
      kidx        <= kidx_d;
      kicking     <= kicking_d;
      resp_k      <= resp_k_d;
      resp_done   <= resp_done_d;
      out_pkt     <= out_pkt_d;
      out_valid   <= out_valid_d;
      in_ready    <= in_ready_d;
      busy        <= busy_d;
      done        <= done_d;
      err_bad_req <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    ts_d        = ts;
    cnt_d       = cnt;
    fin_d       = fin;
    kidx_d      = kidx;
    kicking_d   = kicking;
    resp_k_d    = resp_k;
    resp_done_d = resp_done;
    out_pkt_d   = out_pkt;
    out_valid_d = out_valid;
    done_d      = done;
    err_d       = 1'b0;
    ram_raddr_c = '0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_KICK;
          ts_d      = '0;
          cnt_d     = '0;
          fin_d     = '0;
          kidx_d    = '0;
          kicking_d = 1'b1;
          done_d    = 1'b0;
        end
      end

      S_KICK: begin
        ram_raddr_c  = row_addr(ts, ROW_W'(kidx));
        resp_k_d     = kidx;
        resp_done_d  = 1'b0;
        cnt_d[kidx]  = CNT_W'(1);
        state_d      = S_LOOKUP;
      end

      S_WAIT_REQ: begin
        // Address is formed from the live request so the row is ready in LOOKUP.
        ram_raddr_c = row_addr(ts, ROW_W'(req_idx) + ROW_W'(cnt[req_idx]));
        if (in_valid && in_ready) begin
          if (!req_ok) begin
            err_d = 1'b1;
          end else begin
            resp_k_d = req_idx;
            state_d  = S_LOOKUP;
            if (cnt[req_idx] < CNT_W'(OUTPUT_DIM)) begin
              cnt_d[req_idx] = cnt[req_idx] + CNT_W'(1);
              resp_done_d    = 1'b0;
            end else begin
              fin_d[req_idx] = 1'b1;
              resp_done_d    = 1'b1;
            end
          end
        end
      end

      S_LOOKUP: begin
        out_pkt_d.dest   = DEST_W'(PPE_BASE_ID) + DEST_W'(resp_k);
        out_pkt_d.opcode = resp_done ? OP_TIMESTEP_DONE : OP_INPUT;
        out_pkt_d.data   = resp_done ? '0 : ram_rdata;
        out_valid_d      = 1'b1;
        state_d          = S_SEND;
      end

      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (kicking) begin
            if (kidx == PE_W'(NUM_PE - 1)) begin
              kicking_d = 1'b0;
              state_d   = S_WAIT_REQ;
            end else begin
              kidx_d  = kidx + PE_W'(1);
              state_d = S_KICK;
            end
          end else if (&fin) begin
            if (ts < TS_W'(NUM_TS - 1)) begin
              ts_d      = ts + TS_W'(1);
              cnt_d     = '0;
              fin_d     = '0;
              kidx_d    = '0;
              kicking_d = 1'b1;
              state_d   = S_KICK;
            end else begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            state_d = S_WAIT_REQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_WAIT_REQ);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE));
  end

endmodule

// File: tb/tb_imem_input_server.sv
// Scoreboard bench for imem_input_server: stimulus queues expected packets,
// a negedge monitor pops and compares every accepted response.
module tb_imem_input_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [0:0]  load_ts;
  logic [4:0]  load_row;
  logic [24:0] load_data;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_packet;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_packet;
  logic        busy;
  logic        done;
  logic        err_bad_req;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  imem_input_server dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_ts(load_ts), .load_row(load_row),
    .load_data(load_data), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_packet(in_packet), .out_valid(out_valid), .out_ready(out_ready),
    .out_packet(out_packet), .busy(busy), .done(done), .err_bad_req(err_bad_req)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] mk(input int d, input int op, input int data);
    return {4'(d), 4'(op), 25'(data)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every response accepted downstream must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pkt: got %0h required none", out_packet);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if (out_packet !== e) begin
          n_errors++;
          $display("FAIL pkt: got %0h required %0h", out_packet, e);
        end
      end
    end
  end

  task automatic send_req(input int d, input int op);
    bit got;
    got = 1'b0;
    in_packet = mk(d, op, 0);
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: got no in_ready required in_ready");
    end
  endtask

  // Valid request: response must appear exactly two cycles after the handshake.
  task automatic good_req(input int op, input logic [32:0] e);
    exp_q.push_back(e);
    send_req(11, op);
    chk("lat_n1", 64'(out_valid), 64'd0);
    tick();
    chk("lat_n2", 64'(out_valid), 64'd1);
  endtask

  task automatic bad_req(input string name, input int d, input int op);
    send_req(d, op);
    chk({name, "_err"}, 64'(err_bad_req), 64'd1);
    chk({name, "_noval0"}, 64'(out_valid), 64'd0);
    tick();
    chk({name, "_errpulse"}, 64'(err_bad_req), 64'd0);
    tick();
    chk({name, "_noval2"}, 64'(out_valid), 64'd0);
  endtask

  task automatic drain(output bit ir_seen);
    bit ok;
    ok = 1'b0;
    ir_seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      if (in_ready) ir_seen = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
  endtask

  // Run PE k from count c0 to the end of its timestep; row r holds r+add.
  task automatic finish_ppe(input int k, input int c0, input int add);
    for (int c = c0; c < 21; c++) good_req(5 + k, mk(5 + k, 1, k + c + add));
    good_req(5 + k, mk(5 + k, 15, 0));
  endtask

  task automatic push_kick(input int add);
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(5 + k, 1, k + add));
  endtask

  initial begin
    bit ir;
    bit hold_bad;
    rst = 1'b1; load_en = 1'b0; load_ts = '0; load_row = '0; load_data = '0;
    start = 1'b0; in_valid = 1'b0; in_packet = '0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_packet", 64'(out_packet), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_bad_req), 64'd0);
    rst = 1'b0;
    tick();

    // Load ts1 then ts0; final row 0 write coincides with start.
    load_en = 1'b1;
    for (int r = 0; r < 25; r++) begin
      load_ts = 1'b1; load_row = 5'(r); load_data = 25'(r + 100); tick();
    end
    for (int r = 24; r >= 1; r--) begin
      load_ts = 1'b0; load_row = 5'(r); load_data = 25'(r + 1); tick();
    end
    load_row = 5'd0; load_data = 25'd1; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    push_kick(1);
    drain(ir);
    chk("kick0_in_ready_low", 64'(ir), 64'd0);
    chk("kick0_in_ready_after", 64'(in_ready), 64'd1);

    good_req(7, mk(7, 1, 4));
    drain(ir);

    // Backpressure: response held stable and no new request accepted.
    out_ready = 1'b0;
    exp_q.push_back(mk(6, 1, 3));
    send_req(11, 6);
    tick();
    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || out_packet !== mk(6, 1, 3) || in_ready) hold_bad = 1'b1;
    end
    chk("hold_stable", 64'(hold_bad), 64'd0);
    out_ready = 1'b1;
    drain(ir);

    finish_ppe(0, 1, 1);
    drain(ir);
    bad_req("bad_dest", 3, 6);
    bad_req("bad_pe", 11, 12);
    bad_req("bad_fin", 11, 5);

    finish_ppe(1, 2, 1);
    finish_ppe(2, 2, 1);
    finish_ppe(3, 1, 1);
    finish_ppe(4, 1, 1);
    push_kick(100);
    drain(ir);
    chk("kick1_in_ready_low", 64'(ir), 64'd0);
    chk("ts1_busy", 64'(busy), 64'd1);
    chk("ts1_done_low", 64'(done), 64'd0);

    for (int k = 0; k < 5; k++) finish_ppe(k, 1, 100);
    drain(ir);
    chk("final_done", 64'(done), 64'd1);
    chk("final_busy", 64'(busy), 64'd0);
    chk("final_in_ready", 64'(in_ready), 64'd0);

    // Reset while a kick packet is pending downstream, then replay.
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick();
    end
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    push_kick(1);
    drain(ir);
    chk("replay_in_ready", 64'(in_ready), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
